// File: rtl/lsu_dmem_rv32.sv
// Load/store unit for an RV32 pipeline. It accepts one memory op from EX and runs a
// req/ack transaction on the data-memory port. Loads are aligned and sign- or zero-extended
// before they are handed to the MA stage. The unit stalls the pipeline while it is busy.
module lsu_dmem_rv32 #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iValid,
  input  logic        iRW,
  input  logic [2:0]  iFunct3,
  input  logic [31:0] iAddr,
  input  logic [31:0] iStoreData,
  input  logic [4:0]  iDregADDR,
  output logic        oReady,
  output logic        oStallD,
  output logic        oDmemReq,
  output logic        oDmemWE,
  output logic [31:0] oDmemAddr,
  output logic [31:0] oDmemWData,
  output logic [3:0]  oDmemBE,
  input  logic        iDmemAck,
  input  logic [31:0] iDmemRData,
  output logic        oValid,
  output logic [4:0]  oDregADDR,
  output logic [31:0] oDregDATA,
  output logic        oFault
);

  // The wait counter stops one short of TIMEOUT, so req stays high for exactly TIMEOUT cycles.
  localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [4:0]  dreg_addr_q, dreg_addr_d;
  logic [31:0] dreg_data_q, dreg_data_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rw_q, rw_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  rd_q, rd_d;

  function automatic logic is_illegal(input logic rw, input logic [2:0] f3, input logic [1:0] a);
    logic bad;
    case (f3)
      3'b000:         bad = 1'b0;
      3'b001:         bad = a[0];
      3'b010:         bad = (a != 2'b00);
      3'b100, 3'b101: bad = ~rw;        // unsigned variants exist only for loads
      default:        bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] load_align(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
    logic [31:0] sh;
    logic [31:0] res;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  res = {{24{sh[7]}}, sh[7:0]};
      3'b001:  res = {{16{sh[15]}}, sh[15:0]};
      3'b100:  res = {24'd0, sh[7:0]};
      3'b101:  res = {16'd0, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3)
      3'b000:  be = 4'b0001 << off;
      3'b001:  be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3)
      3'b000:  w = {4{d[7:0]}};
      3'b001:  w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Next-state and next-output logic; everything the unit drives comes out of a register.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    valid_d     = 1'b0;
    fault_d     = 1'b0;
    dreg_addr_d = dreg_addr_q;
    dreg_data_d = dreg_data_q;
    cnt_d       = cnt_q;
    rw_d        = rw_q;
    f3_d        = f3_q;
    off_d       = off_q;
    rd_d        = rd_q;
    case (state_q)
      S_IDLE: begin
        if (iValid) begin
          rw_d  = iRW;
          f3_d  = iFunct3;
          off_d = iAddr[1:0];
          rd_d  = iDregADDR;
          if (is_illegal(iRW, iFunct3, iAddr[1:0])) begin
            // Illegal ops never reach memory; they complete straight away as a fault.
            state_d     = S_RESP;
            valid_d     = 1'b1;
            fault_d     = 1'b1;
            dreg_addr_d = 5'd0;
            dreg_data_d = 32'd0;
          end else begin
            state_d = S_REQ;
            req_d   = 1'b1;
            we_d    = ~iRW;
            addr_d  = {iAddr[31:2], 2'b00};
            be_d    = iRW ? 4'b1111 : store_be(iFunct3, iAddr[1:0]);
            wdata_d = iRW ? 32'd0 : store_wdata(iFunct3, iStoreData);
            cnt_d   = 8'd0;
          end
        end
      end
      S_REQ: begin
        if (iDmemAck) begin
          state_d     = S_RESP;
          req_d       = 1'b0;
          valid_d     = 1'b1;
          dreg_addr_d = rw_q ? rd_q : 5'd0;
          dreg_data_d = rw_q ? load_align(f3_q, off_q, iDmemRData) : 32'd0;
        end else if (cnt_q == TIMEOUT_M1) begin
          state_d     = S_RESP;
          req_d       = 1'b0;
          valid_d     = 1'b1;
          fault_d     = 1'b1;
          dreg_addr_d = 5'd0;
          dreg_data_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state and handshake control; reset aborts any transaction in flight.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  // Memory-port data, latched op fields and MA-stage results.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      dreg_addr_q <= 5'd0;
      dreg_data_q <= 32'd0;
      rw_q        <= 1'b0;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
      rd_q        <= 5'd0;
    end else begin
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      dreg_addr_q <= dreg_addr_d;
      dreg_data_q <= dreg_data_d;
      rw_q        <= rw_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
    end
  end

  assign oReady     = (state_q == S_IDLE);
  assign oStallD    = ~oReady;
  assign oDmemReq   = req_q;
  assign oDmemWE    = we_q;
  assign oDmemAddr  = addr_q;
  assign oDmemWData = wdata_q;
  assign oDmemBE    = be_q;
  assign oValid     = valid_q;
  assign oFault     = fault_q;
  assign oDregADDR  = dreg_addr_q;
  assign oDregDATA  = dreg_data_q;

endmodule

// File: tb/tb_lsu_dmem_rv32.sv
// Directed testbench for lsu_dmem_rv32 with hand-computed expected values.
module tb_lsu_dmem_rv32;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iValid = 1'b0;
  logic        iRW = 1'b0;
  logic [2:0]  iFunct3 = 3'd0;
  logic [31:0] iAddr = 32'd0;
  logic [31:0] iStoreData = 32'd0;
  logic [4:0]  iDregADDR = 5'd0;
  logic        oReady, oStallD, oDmemReq, oDmemWE;
  logic [31:0] oDmemAddr, oDmemWData;
  logic [3:0]  oDmemBE;
  logic        iDmemAck = 1'b0;
  logic [31:0] iDmemRData = 32'd0;
  logic        oValid;
  logic [4:0]  oDregADDR;
  logic [31:0] oDregDATA;
  logic        oFault;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations collected by run_op.
  int          req_n, lat;
  logic        got_v, v_fault, unstable, cap_we;
  logic [31:0] v_data, cap_addr, cap_wdata;
  logic [4:0]  v_addr;
  logic [3:0]  cap_be;

  lsu_dmem_rv32 #(.TIMEOUT(15)) dut (
    .iCLK(iCLK), .iRST(iRST), .iValid(iValid), .iRW(iRW), .iFunct3(iFunct3),
    .iAddr(iAddr), .iStoreData(iStoreData), .iDregADDR(iDregADDR),
    .oReady(oReady), .oStallD(oStallD), .oDmemReq(oDmemReq), .oDmemWE(oDmemWE),
    .oDmemAddr(oDmemAddr), .oDmemWData(oDmemWData), .oDmemBE(oDmemBE),
    .iDmemAck(iDmemAck), .iDmemRData(iDmemRData), .oValid(oValid),
    .oDregADDR(oDregADDR), .oDregDATA(oDregDATA), .oFault(oFault)
  );

  always #5 iCLK = ~iCLK;

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one op for a single accept cycle; returns in the first cycle after acceptance.
  task automatic issue(input logic rw, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] sd, input logic [4:0] rd);
    iValid = 1'b1; iRW = rw; iFunct3 = f3; iAddr = addr; iStoreData = sd; iDregADDR = rd;
    tick();
    iValid = 1'b0;
  endtask

  // Serve the memory side until oValid; ack_after = n acks in the n-th REQ cycle, 0 = never.
  task automatic run_op(input int ack_after, input logic [31:0] rdata);
    req_n = 0; lat = 0; got_v = 1'b0; unstable = 1'b0;
    for (int k = 1; k <= 40 && !got_v; k++) begin
      if (oValid) begin
        got_v = 1'b1; lat = k;
        v_data = oDregDATA; v_addr = oDregADDR; v_fault = oFault;
      end else begin
        if (oDmemReq) begin
          req_n++;
          if (req_n == 1) begin
            cap_addr = oDmemAddr; cap_wdata = oDmemWData; cap_be = oDmemBE; cap_we = oDmemWE;
          end else if (oDmemAddr !== cap_addr || oDmemWData !== cap_wdata ||
                       oDmemBE !== cap_be || oDmemWE !== cap_we) begin
            unstable = 1'b1;
          end
          iDmemAck = (req_n == ack_after);
          iDmemRData = rdata;
        end else begin
          iDmemAck = 1'b0;
        end
        tick();
      end
    end
    iDmemAck = 1'b0;
    check_eq("op_completes", 32'(got_v), 32'd1);
  endtask

  // Checks the cycle after the oValid pulse.
  task automatic after_pulse(input string tag);
    tick();
    check_eq({tag, "_valid_drop"}, 32'(oValid), 32'd0);
    check_eq({tag, "_ready_again"}, 32'(oReady), 32'd1);
  endtask

  initial begin
    // Reset
    tick(); tick();
    iRST = 1'b0;
    check_eq("rst_ready", 32'(oReady), 32'd1);
    check_eq("rst_stall", 32'(oStallD), 32'd0);
    check_eq("rst_req", 32'(oDmemReq), 32'd0);
    check_eq("rst_valid", 32'(oValid), 32'd0);
    check_eq("rst_be", 32'(oDmemBE), 32'd0);
    check_eq("rst_dregdata", oDregDATA, 32'd0);
    tick();

    // 1. LW 0x100, ack in first REQ cycle
    issue(1'b1, 3'b010, 32'h100, 32'd0, 5'd5);
    check_eq("lw_stall", 32'(oStallD), 32'd1);
    run_op(1, 32'hDEADBEEF);
    check_eq("lw_addr", cap_addr, 32'h100);
    check_eq("lw_be", 32'(cap_be), 32'hF);
    check_eq("lw_we", 32'(cap_we), 32'd0);
    check_eq("lw_latency", lat, 32'd2);
    check_eq("lw_data", v_data, 32'hDEADBEEF);
    check_eq("lw_rd", 32'(v_addr), 32'd5);
    check_eq("lw_fault", 32'(v_fault), 32'd0);
    check_eq("lw_req_drop", 32'(oDmemReq), 32'd0);
    after_pulse("lw");

    // 2. LB / LBU at byte 3
    issue(1'b1, 3'b000, 32'h103, 32'd0, 5'd7);
    run_op(1, 32'h80123456);
    check_eq("lb_addr", cap_addr, 32'h100);
    check_eq("lb_data", v_data, 32'hFFFFFF80);
    after_pulse("lb");
    issue(1'b1, 3'b100, 32'h103, 32'd0, 5'd7);
    run_op(1, 32'h80123456);
    check_eq("lbu_data", v_data, 32'h00000080);
    after_pulse("lbu");

    // LH / LHU at upper half
    issue(1'b1, 3'b001, 32'h102, 32'd0, 5'd9);
    run_op(2, 32'h8001CAFE);
    check_eq("lh_data", v_data, 32'hFFFF8001);
    check_eq("lh_rd", 32'(v_addr), 32'd9);
    after_pulse("lh");
    issue(1'b1, 3'b101, 32'h102, 32'd0, 5'd9);
    run_op(1, 32'h8001CAFE);
    check_eq("lhu_data", v_data, 32'h00008001);
    after_pulse("lhu");

    // 3. SH 0x202, ack in third REQ cycle
    issue(1'b0, 3'b001, 32'h202, 32'h1234ABCD, 5'd3);
    run_op(3, 32'h0);
    check_eq("sh_addr", cap_addr, 32'h200);
    check_eq("sh_be", 32'(cap_be), 32'hC);
    check_eq("sh_wdata", cap_wdata, 32'hABCDABCD);
    check_eq("sh_we", 32'(cap_we), 32'd1);
    check_eq("sh_req_cycles", req_n, 32'd3);
    check_eq("sh_stable", 32'(unstable), 32'd0);
    check_eq("sh_latency", lat, 32'd4);
    check_eq("sh_rd", 32'(v_addr), 32'd0);
    check_eq("sh_dregdata", v_data, 32'd0);
    check_eq("sh_fault", 32'(v_fault), 32'd0);
    after_pulse("sh");

    // SB byte 1
    issue(1'b0, 3'b000, 32'h301, 32'hFFFFFF55, 5'd0);
    run_op(1, 32'h0);
    check_eq("sb_be", 32'(cap_be), 32'h2);
    check_eq("sb_wdata", cap_wdata, 32'h55555555);
    after_pulse("sb");

    // 4. Illegal ops: misaligned LW, misaligned LH, store funct3 100, funct3 011
    issue(1'b1, 3'b010, 32'h101, 32'd0, 5'd4);
    run_op(0, 32'hFFFFFFFF);
    check_eq("lw_mis_req", req_n, 32'd0);
    check_eq("lw_mis_latency", lat, 32'd1);
    check_eq("lw_mis_fault", 32'(v_fault), 32'd1);
    check_eq("lw_mis_data", v_data, 32'd0);
    check_eq("lw_mis_rd", 32'(v_addr), 32'd0);
    after_pulse("lw_mis");
    issue(1'b1, 3'b001, 32'h3, 32'd0, 5'd4);
    run_op(0, 32'hFFFFFFFF);
    check_eq("lh_mis_req", req_n, 32'd0);
    check_eq("lh_mis_fault", 32'(v_fault), 32'd1);
    check_eq("lh_mis_latency", lat, 32'd1);
    after_pulse("lh_mis");
    issue(1'b0, 3'b100, 32'h10, 32'd1, 5'd0);
    run_op(0, 32'h0);
    check_eq("sbu_fault", 32'(v_fault), 32'd1);
    check_eq("sbu_req", req_n, 32'd0);
    after_pulse("sbu");
    issue(1'b1, 3'b011, 32'h10, 32'd0, 5'd1);
    run_op(0, 32'h0);
    check_eq("f3_011_fault", 32'(v_fault), 32'd1);
    after_pulse("f3_011");

    // 5. Timeout, then a late ack is ignored
    issue(1'b1, 3'b010, 32'h400, 32'd0, 5'd6);
    run_op(0, 32'h12345678);
    check_eq("to_req_cycles", req_n, 32'd15);
    check_eq("to_latency", lat, 32'd16);
    check_eq("to_fault", 32'(v_fault), 32'd1);
    check_eq("to_data", v_data, 32'd0);
    check_eq("to_req_low", 32'(oDmemReq), 32'd0);
    after_pulse("to");
    iDmemAck = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("late_ack_valid", 32'(oValid), 32'd0);
      check_eq("late_ack_ready", 32'(oReady), 32'd1);
    end
    iDmemAck = 1'b0;
    tick();

    // 6. Reset on the second REQ cycle
    issue(1'b1, 3'b010, 32'h500, 32'd0, 5'd8);
    check_eq("rstmid_req1", 32'(oDmemReq), 32'd1);
    tick();
    check_eq("rstmid_req2", 32'(oDmemReq), 32'd1);
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    check_eq("rstmid_req", 32'(oDmemReq), 32'd0);
    check_eq("rstmid_ready", 32'(oReady), 32'd1);
    check_eq("rstmid_addr", oDmemAddr, 32'd0);
    check_eq("rstmid_be", 32'(oDmemBE), 32'd0);
    check_eq("rstmid_valid", 32'(oValid), 32'd0);
    iDmemAck = 1'b1;
    iDmemRData = 32'hCAFEF00D;
    tick();
    iDmemAck = 1'b0;
    check_eq("rstmid_ack_valid", 32'(oValid), 32'd0);
    check_eq("rstmid_ack_req", 32'(oDmemReq), 32'd0);
    tick();
    check_eq("rstmid_ack_valid2", 32'(oValid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
